// File: rtl/mech_resonator_bank_if.sv
// Host coefficient write port for the mechanical resonator bank.
// Address layout is {mode, sel}; sel 0=cr, 1=ci, 2=gain, 3=clear state.
interface mech_resonator_bank_if #(
  parameter int unsigned mode_aw = 3
) ();
  logic                   host_we;
  logic [mode_aw+1:0]     host_addr;
  logic signed [17:0]     host_data;

  modport master (output host_we, host_addr, host_data);
  modport slave  (input  host_we, host_addr, host_data);
endinterface

// File: rtl/mech_resonator_bank.sv
// Time-multiplexed bank of damped-rotation mechanical eigenmodes: streams displacements out,
// captures per-mode drive, then steps every mode once per frame through a 2-stage pipeline.
module mech_resonator_bank #(
  parameter int unsigned n_modes      = 8,
  parameter int unsigned mode_aw      = 3,
  parameter int unsigned period       = 128,
  parameter int unsigned drive_offset = 12
) (
  input  logic                        clk,
  input  logic                        reset_n,
  mech_resonator_bank_if.slave        host,
  output logic                        start,
  output logic signed [17:0]          mech_x,
  input  logic signed [17:0]          eig_drive,
  output logic [$clog2(period)-1:0]   frame_cnt
);

  localparam int unsigned cnt_w = $clog2(period);
  localparam logic [cnt_w-1:0] cnt_max   = cnt_w'(period - 1);
  localparam logic [cnt_w-1:0] cap_lo    = cnt_w'(drive_offset);
  localparam logic [cnt_w-1:0] iss_lo    = cnt_w'(drive_offset + n_modes);
  localparam logic [cnt_w-1:0] iss_hi    = cnt_w'(drive_offset + 2 * n_modes);
  localparam logic [cnt_w-1:0] n_modes_c = cnt_w'(n_modes);

  typedef logic signed [17:0] s18_t;
  typedef logic signed [35:0] s36_t;
  typedef logic signed [36:0] s37_t;

  function automatic s36_t mul18(s18_t a, s18_t b);
    s36_t ae;
    s36_t be;
    ae = 36'(a);
    be = 36'(b);
    return ae * be;
  endfunction

  function automatic s18_t sat18(s37_t v);
    s18_t r;
    if (v > 37'sd131071)       r = 18'sd131071;
    else if (v < -37'sd131072) r = -18'sd131072;
    else                       r = v[17:0];
    return r;
  endfunction

  logic [cnt_w-1:0] cnt_q;
  s18_t             mech_x_q;

  s18_t x_q    [n_modes];
  s18_t y_q    [n_modes];
  s18_t drv_q  [n_modes];
  s18_t cr_q   [n_modes];
  s18_t ci_q   [n_modes];
  s18_t gain_q [n_modes];
  s18_t cr_shd_q   [n_modes];
  s18_t ci_shd_q   [n_modes];
  s18_t gain_shd_q [n_modes];

  logic               s1_vld_q;
  logic [mode_aw-1:0] s1_mode_q;
  s36_t               p_xr_q, p_xi_q, p_yi_q, p_yr_q, p_d_q;
  logic               s2_vld_q;
  logic [mode_aw-1:0] s2_mode_q;
  s18_t               nx_q, ny_q;

  logic [mode_aw-1:0] wr_mode;
  logic [1:0]         wr_sel;
  logic               clr_en;
  logic               cap_en, iss_en;
  logic [mode_aw-1:0] cap_mode, iss_mode;
  s36_t               p_xr_d, p_xi_d, p_yi_d, p_yr_d, p_d_d;
  s37_t               sx, sy, dx, acc_x, acc_y;
  s18_t               nx_d, ny_d;

  assign wr_mode = host.host_addr[mode_aw+1:2];
  assign wr_sel  = host.host_addr[1:0];
  assign clr_en  = host.host_we && (wr_sel == 2'd3);

  // Start is qualified with reset so it stays low while the bank is held in reset.
  assign start     = reset_n && (cnt_q == '0);
  assign mech_x    = mech_x_q;
  assign frame_cnt = cnt_q;

  always_comb begin
    cap_en   = (cnt_q >= cap_lo) && (cnt_q < iss_lo);
    cap_mode = mode_aw'(cnt_q - cap_lo);
    iss_en   = (cnt_q >= iss_lo) && (cnt_q < iss_hi);
    iss_mode = mode_aw'(cnt_q - iss_lo);

    p_xr_d = mul18(cr_q[iss_mode],   x_q[iss_mode]);
    p_xi_d = mul18(ci_q[iss_mode],   y_q[iss_mode]);
    p_yi_d = mul18(ci_q[iss_mode],   x_q[iss_mode]);
    p_yr_d = mul18(cr_q[iss_mode],   y_q[iss_mode]);
    p_d_d  = mul18(gain_q[iss_mode], drv_q[iss_mode]);

    sx    = {p_xr_q[35], p_xr_q} - {p_xi_q[35], p_xi_q};
    sy    = {p_yi_q[35], p_yi_q} + {p_yr_q[35], p_yr_q};
    dx    = {p_d_q[35], p_d_q};
    acc_x = (sx >>> 17) + (dx >>> 17);
    acc_y = sy >>> 17;
    nx_d  = sat18(acc_x);
    ny_d  = sat18(acc_y);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      mech_x_q <= '0;
    end else begin
      cnt_q    <= (cnt_q == cnt_max) ? '0 : cnt_q + cnt_w'(1);
      mech_x_q <= (cnt_q < n_modes_c) ? x_q[cnt_q[mode_aw-1:0]] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cr_shd_q   <= '{default: '0};
      ci_shd_q   <= '{default: '0};
      gain_shd_q <= '{default: '0};
      cr_q       <= '{default: '0};
      ci_q       <= '{default: '0};
      gain_q     <= '{default: '0};
    end else begin
      if (host.host_we) begin
        case (wr_sel)
          2'd0:    cr_shd_q[wr_mode]   <= host.host_data;
          2'd1:    ci_shd_q[wr_mode]   <= host.host_data;
          2'd2:    gain_shd_q[wr_mode] <= host.host_data;
          default: ;
        endcase
      end
      // Copy uses the pre-edge shadow, so a write in frame cycle 0 waits a frame.
      if (cnt_q == '0) begin
        cr_q   <= cr_shd_q;
        ci_q   <= ci_shd_q;
        gain_q <= gain_shd_q;
      end
    end
  end

  // A clear kills any in-flight update of its mode that already read the old state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q  <= 1'b0;
      s1_mode_q <= '0;
      p_xr_q    <= '0;
      p_xi_q    <= '0;
      p_yi_q    <= '0;
      p_yr_q    <= '0;
      p_d_q     <= '0;
      s2_vld_q  <= 1'b0;
      s2_mode_q <= '0;
      nx_q      <= '0;
      ny_q      <= '0;
    end else begin
      s1_vld_q  <= iss_en && !(clr_en && (wr_mode == iss_mode));
      s1_mode_q <= iss_mode;
      p_xr_q    <= p_xr_d;
      p_xi_q    <= p_xi_d;
      p_yi_q    <= p_yi_d;
      p_yr_q    <= p_yr_d;
      p_d_q     <= p_d_d;
      s2_vld_q  <= s1_vld_q && !(clr_en && (wr_mode == s1_mode_q));
      s2_mode_q <= s1_mode_q;
      nx_q      <= nx_d;
      ny_q      <= ny_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q   <= '{default: '0};
      y_q   <= '{default: '0};
      drv_q <= '{default: '0};
    end else begin
      if (cap_en) drv_q[cap_mode] <= eig_drive;
      for (int unsigned k = 0; k < n_modes; k++) begin
        if (clr_en && (wr_mode == mode_aw'(k))) begin
          x_q[k] <= '0;
          y_q[k] <= '0;
        end else if (s2_vld_q && (s2_mode_q == mode_aw'(k))) begin
          x_q[k] <= nx_q;
          y_q[k] <= ny_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mech_resonator_bank.sv
// Directed bench for mech_resonator_bank: frame timing, impulse, rotation, saturation,
// shadow-bank timing, clear collisions and mid-window reset.
module tb_mech_resonator_bank;

  localparam int Period = 128;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic signed [17:0] mech_x;
  logic signed [17:0] eig_drive;
  logic [6:0]         frame_cnt;

  mech_resonator_bank_if #(.mode_aw(3)) host_if ();

  mech_resonator_bank #(
    .n_modes      (8),
    .mode_aw      (3),
    .period       (Period),
    .drive_offset (12)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .host      (host_if.slave),
    .start     (start),
    .mech_x    (mech_x),
    .eig_drive (eig_drive),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cur_f    = 0;
  int cur_c    = 0;
  int exp_tab [0:10][0:7];

  task automatic check_eq(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s frame=%0d cycle=%0d got=%0d exp=%0d", tag, cur_f, cur_c, got, exp);
    end
  endtask

  task automatic idle_inputs();
    eig_drive         = '0;
    host_if.host_we   = 1'b0;
    host_if.host_addr = '0;
    host_if.host_data = '0;
  endtask

  task automatic host_write(int mode, int sel, int data);
    host_if.host_we   = 1'b1;
    host_if.host_addr = 5'(mode * 4 + sel);
    host_if.host_data = 18'(data);
  endtask

  task automatic apply_stim(int f, int c);
    idle_inputs();
    if (f == 3 && c == 12)                      eig_drive = 18'sd40000;
    if (c == 13 && f >= 3 && f <= 9)            eig_drive = 18'sd40000;
    if (c == 14 && (f == 3 || f == 5 || f == 6)) eig_drive = 18'sd40000;
    if (c == 15 && f >= 5 && f <= 9)            eig_drive = 18'sd131071;
    if (f == 2 && c == 30) host_write(0, 2, 65536);
    if (f == 2 && c == 31) host_write(2, 2, 65536);
    if (f == 2 && c == 32) host_write(1, 2, 65536);
    if (f == 3 && c == 40) host_write(0, 1, 131071);
    if (f == 4 && c == 40) host_write(3, 0, 131071);
    if (f == 4 && c == 41) host_write(3, 2, 131071);
    if (f == 5 && c == 20) host_write(2, 2, 0);
    if (f == 7 && c == 23) host_write(1, 3, 0);
    if (f == 8 && c == 18) host_write(1, 3, 0);
    if (f == 9 && c == 21) host_write(1, 3, 0);
  endtask

  task automatic check_cycle(int f, int c, bit post);
    int exp;
    cur_f = f;
    cur_c = c;
    exp   = (!post && c >= 1 && c <= 8) ? exp_tab[f][c-1] : 0;
    check_eq("frame_cnt", int'(frame_cnt), c);
    check_eq("start", int'(start), (c == 0) ? 1 : 0);
    check_eq("mech_x", int'(mech_x), exp);
  endtask

  // Entered just after the negedge at which reset_n was released (frame cycle 0).
  task automatic run(int t_stop, bit post);
    for (int t = 0; t < t_stop; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      check_cycle(t / Period, t % Period, post);
      if (post) idle_inputs();
      else      apply_stim(t / Period, t % Period);
    end
  endtask

  task automatic check_reset_state();
    check_eq("rst_start", int'(start), 0);
    check_eq("rst_mech_x", int'(mech_x), 0);
    check_eq("rst_frame_cnt", int'(frame_cnt), 0);
  endtask

  initial begin
    for (int f = 0; f <= 10; f++)
      for (int m = 0; m < 8; m++) exp_tab[f][m] = 0;
    // mode 0: impulse then rotation by ci=131071
    exp_tab[4][0] = 20000;  exp_tab[5][0] = 0;      exp_tab[6][0] = -19999;
    exp_tab[7][0] = 0;      exp_tab[8][0] = 19998;  exp_tab[9][0] = 0;
    exp_tab[10][0] = -19997;
    // mode 1: steady drive, clears at commit (f7), before issue (f8), at issue (f9)
    exp_tab[4][1] = 20000;  exp_tab[5][1] = 20000;  exp_tab[6][1] = 20000;
    exp_tab[7][1] = 20000;  exp_tab[8][1] = 0;      exp_tab[9][1] = 20000;
    exp_tab[10][1] = 0;
    // mode 2: decaying impulse, then shadow gain write mid-frame
    exp_tab[4][2] = 20000;  exp_tab[6][2] = 20000;
    // mode 3: saturating integrator
    exp_tab[6][3] = 131070; exp_tab[7][3] = 131071; exp_tab[8][3] = 131071;
    exp_tab[9][3] = 131071; exp_tab[10][3] = 131071;

    reset_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    cur_f = -1;
    cur_c = -1;
    check_reset_state();

    @(negedge clk);
    reset_n = 1'b1;
    run(10 * Period + 24, 1'b0);

    // Assert reset in the middle of frame 10's update window.
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    #1;
    cur_f = 10;
    cur_c = 24;
    check_reset_state();
    repeat (2) begin
      @(negedge clk);
      #1;
      check_reset_state();
    end

    @(negedge clk);
    reset_n = 1'b1;
    run(2 * Period, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
